// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared CP0 definitions for the exception controller.
// Holds CP0 register addresses, ExcCode values, Status/Cause bit positions,
// the sequencer state encoding and small helpers that build CP0 write data.
package exc_ctrl_pkg;

    // CP0 register addresses
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;
    localparam logic [4:0] EXC_TR      = 5'd13;

    // Status register bit positions
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LSB  = 8;
    localparam int STATUS_IM_MSB  = 15;

    // Cause register bit positions
    localparam int CAUSE_CODE_LSB = 2;
    localparam int CAUSE_CODE_MSB = 6;
    localparam int CAUSE_IP_LSB   = 8;
    localparam int CAUSE_IP_MSB   = 15;
    localparam int CAUSE_BD_BIT   = 31;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_EPC    = 3'd1,
        WR_CAUSE  = 3'd2,
        WR_STATUS = 3'd3,
        REDIRECT  = 3'd4
    } exc_state_e;

    // EPC points back at the branch when the faulting instruction sits in a delay slot
    function automatic logic [31:0] epc_value(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

    // Cause keeps every bit except BD and ExcCode
    function automatic logic [31:0] cause_value(input logic [31:0] cause,
                                                input logic        bd,
                                                input logic [4:0]  code);
        logic [31:0] c;
        c = cause;
        c[CAUSE_BD_BIT] = bd;
        c[CAUSE_CODE_MSB:CAUSE_CODE_LSB] = code;
        return c;
    endfunction

    // Status keeps every bit except EXL
    function automatic logic [31:0] status_value(input logic [31:0] status, input logic exl);
        logic [31:0] s;
        s = status;
        s[STATUS_EXL_BIT] = exl;
        return s;
    endfunction

endpackage

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception / interrupt / ERET sequencer.
// Accepts one event in IDLE, flushes the pipeline, walks the CP0 writes
// (EPC, Cause, Status) one per cycle, then issues a single redirect strobe.
// Optional feature macro: EXC_DELAY_SLOT_EN enables branch-delay-slot
// handling (EPC = pc-4 and Cause.BD set); undefined, the BD input is ignored.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req_i,
    input  logic [4:0]  exc_code_i,
    input  logic        eret_i,
    input  logic [31:0] exc_pc_i,
    input  logic        in_delay_slot_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_wdata_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        new_pc_valid_o,
    output logic [31:0] new_pc_o
);

    exc_state_e  state;
    logic [4:0]  code_q;
    logic        bd_q;
    logic        is_eret_q;
    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic        stall_q;

    logic        int_pending;
    logic        accept;
    logic        take_eret;
    logic        bd_eff;
    logic [4:0]  accept_code;

`ifdef EXC_DELAY_SLOT_EN
    assign bd_eff = in_delay_slot_i;
`else
    // Delay-slot information is deliberately discarded in this build
    assign bd_eff = 1'b0 & in_delay_slot_i;
`endif

    // Interrupt is pending when enabled, not already at exception level, and an unmasked line is raised
    assign int_pending = status_i[STATUS_IE_BIT] & ~status_i[STATUS_EXL_BIT] &
                         (|(cause_i[CAUSE_IP_MSB:CAUSE_IP_LSB] & status_i[STATUS_IM_MSB:STATUS_IM_LSB]));

    assign accept      = (state == IDLE) & ~rst & (int_pending | exc_req_i | eret_i);
    assign take_eret   = ~int_pending & ~exc_req_i & eret_i;
    assign accept_code = int_pending ? EXC_INT : (exc_req_i ? exc_code_i : 5'd0);

    // Flush is a pulse in the accepting cycle; stall covers that cycle and every sequencing state
    assign flush_o = accept;
    assign stall_o = stall_q | accept;

    // Sequencer: state, latched event context and registered CP0/redirect outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            code_q         <= 5'd0;
            bd_q           <= 1'b0;
            is_eret_q      <= 1'b0;
            status_q       <= 32'd0;
            cause_q        <= 32'd0;
            epc_q          <= 32'd0;
            stall_q        <= 1'b0;
            cp0_we_o       <= 1'b0;
            cp0_waddr_o    <= 5'd0;
            cp0_wdata_o    <= 32'd0;
            new_pc_valid_o <= 1'b0;
            new_pc_o       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    new_pc_valid_o <= 1'b0;
                    new_pc_o       <= 32'd0;
                    if (accept) begin
                        code_q    <= accept_code;
                        bd_q      <= bd_eff;
                        is_eret_q <= take_eret;
                        status_q  <= status_i;
                        cause_q   <= cause_i;
                        epc_q     <= epc_i;
                        stall_q   <= 1'b1;
                        cp0_we_o  <= 1'b1;
                        if (take_eret) begin
                            state       <= WR_STATUS;
                            cp0_waddr_o <= CP0_STATUS;
                            cp0_wdata_o <= status_value(status_i, 1'b0);
                        end else begin
                            state       <= WR_EPC;
                            cp0_waddr_o <= CP0_EPC;
                            cp0_wdata_o <= epc_value(exc_pc_i, bd_eff);
                        end
                    end else begin
                        stall_q     <= 1'b0;
                        cp0_we_o    <= 1'b0;
                        cp0_waddr_o <= 5'd0;
                        cp0_wdata_o <= 32'd0;
                    end
                end
                WR_EPC: begin
                    state       <= WR_CAUSE;
                    cp0_we_o    <= 1'b1;
                    cp0_waddr_o <= CP0_CAUSE;
                    cp0_wdata_o <= cause_value(cause_q, bd_q, code_q);
                end
                WR_CAUSE: begin
                    state       <= WR_STATUS;
                    cp0_we_o    <= 1'b1;
                    cp0_waddr_o <= CP0_STATUS;
                    cp0_wdata_o <= status_value(status_q, 1'b1);
                end
                WR_STATUS: begin
                    state          <= REDIRECT;
                    cp0_we_o       <= 1'b0;
                    cp0_waddr_o    <= 5'd0;
                    cp0_wdata_o    <= 32'd0;
                    new_pc_valid_o <= 1'b1;
                    new_pc_o       <= is_eret_q ? epc_q : EXC_VECTOR;
                end
                REDIRECT: begin
                    state          <= IDLE;
                    stall_q        <= 1'b0;
                    new_pc_valid_o <= 1'b0;
                    new_pc_o       <= 32'd0;
                end
                default: begin
                    state          <= IDLE;
                    stall_q        <= 1'b0;
                    cp0_we_o       <= 1'b0;
                    cp0_waddr_o    <= 5'd0;
                    cp0_wdata_o    <= 32'd0;
                    new_pc_valid_o <= 1'b0;
                    new_pc_o       <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed, table-driven bench for exc_ctrl.
// Each table record holds one event's inputs and the hand-computed CP0
// writes and redirect target; reset and no-accept cases are hand-written.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        exc_req_i;
    logic [4:0]  exc_code_i;
    logic        eret_i;
    logic [31:0] exc_pc_i;
    logic        in_delay_slot_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_wdata_o;
    logic        flush_o;
    logic        stall_o;
    logic        new_pc_valid_o;
    logic [31:0] new_pc_o;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        string       name;
        logic        exc_req;
        logic [4:0]  code;
        logic        eret;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        extra_req;
        logic        exp_eret;
        logic [31:0] exp_epc;
        logic [31:0] exp_cause;
        logic [31:0] exp_status;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs[7];

    exc_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_req_i      (exc_req_i),
        .exc_code_i     (exc_code_i),
        .eret_i         (eret_i),
        .exc_pc_i       (exc_pc_i),
        .in_delay_slot_i(in_delay_slot_i),
        .status_i       (status_i),
        .cause_i        (cause_i),
        .epc_i          (epc_i),
        .cp0_we_o       (cp0_we_o),
        .cp0_waddr_o    (cp0_waddr_o),
        .cp0_wdata_o    (cp0_wdata_o),
        .flush_o        (flush_o),
        .stall_o        (stall_o),
        .new_pc_valid_o (new_pc_valid_o),
        .new_pc_o       (new_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        exc_req_i       = 1'b0;
        exc_code_i      = 5'd0;
        eret_i          = 1'b0;
        exc_pc_i        = 32'd0;
        in_delay_slot_i = 1'b0;
        status_i        = 32'd0;
        cause_i         = 32'd0;
        epc_i           = 32'd0;
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " idle we"},    cp0_we_o,       1'b0);
        checkOutput({name, " idle stall"}, stall_o,        1'b0);
        checkOutput({name, " idle flush"}, flush_o,        1'b0);
        checkOutput({name, " idle nvld"},  new_pc_valid_o, 1'b0);
        checkOutput({name, " idle npc"},   new_pc_o,       32'd0);
    endtask

    task automatic checkWrite(input string name, input logic [4:0] addr, input logic [31:0] data);
        checkOutput({name, " we"},    cp0_we_o,       1'b1);
        checkOutput({name, " addr"},  cp0_waddr_o,    addr);
        checkOutput({name, " data"},  cp0_wdata_o,    data);
        checkOutput({name, " stall"}, stall_o,        1'b1);
        checkOutput({name, " flush"}, flush_o,        1'b0);
        checkOutput({name, " nvld"},  new_pc_valid_o, 1'b0);
        checkOutput({name, " npc"},   new_pc_o,       32'd0);
    endtask

    task automatic checkRedirect(input string name, input logic [31:0] target);
        checkOutput({name, " redir we"},    cp0_we_o,       1'b0);
        checkOutput({name, " redir stall"}, stall_o,        1'b1);
        checkOutput({name, " redir nvld"},  new_pc_valid_o, 1'b1);
        checkOutput({name, " redir npc"},   new_pc_o,       target);
    endtask

    // Drive one event, then follow the whole sequence cycle by cycle
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        exc_req_i       = v.exc_req;
        exc_code_i      = v.code;
        eret_i          = v.eret;
        exc_pc_i        = v.pc;
        in_delay_slot_i = v.bd;
        status_i        = v.status;
        cause_i         = v.cause;
        epc_i           = v.epc;
        #1;
        checkOutput({v.name, " accept flush"}, flush_o,  1'b1);
        checkOutput({v.name, " accept stall"}, stall_o,  1'b1);
        checkOutput({v.name, " accept we"},    cp0_we_o, 1'b0);
        @(negedge clk);
        clearInputs();
        if (v.exp_eret) begin
            checkWrite({v.name, " status"}, CP0_STATUS, v.exp_status);
            @(negedge clk);
            checkRedirect(v.name, v.exp_target);
        end else begin
            checkWrite({v.name, " epc"}, CP0_EPC, v.exp_epc);
            @(negedge clk);
            if (v.extra_req) begin
                exc_req_i  = 1'b1;
                exc_code_i = EXC_SYSCALL;
                exc_pc_i   = 32'h0000_9000;
                #1;
                checkOutput({v.name, " ignored req flush"}, flush_o, 1'b0);
            end
            checkWrite({v.name, " cause"}, CP0_CAUSE, v.exp_cause);
            @(negedge clk);
            clearInputs();
            checkWrite({v.name, " status"}, CP0_STATUS, v.exp_status);
            @(negedge clk);
            checkRedirect(v.name, v.exp_target);
        end
        @(negedge clk);
        checkIdle(v.name);
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();

        // name, exc, code, eret, pc, bd, status, cause, epc, extra, exp_eret, exp_epc, exp_cause, exp_status, exp_target
        vecs[0] = '{"irq", 1'b0, 5'd0, 1'b0, 32'h0000_1000, 1'b0, 32'h0000_0401, 32'h0000_0400, 32'h0,
                    1'b0, 1'b0, 32'h0000_1000, 32'h0000_0400, 32'h0000_0403, 32'h0000_0020};
`ifdef EXC_DELAY_SLOT_EN
        vecs[1] = '{"ov_bd", 1'b1, 5'd12, 1'b0, 32'h0000_0100, 1'b1, 32'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 32'h0000_00FC, 32'h8000_0030, 32'h0000_0002, 32'h0000_0020};
        vecs[4] = '{"tr_wrap", 1'b1, 5'd13, 1'b0, 32'h0000_0000, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0,
                    1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFB7, 32'h0000_0002, 32'h0000_0020};
`else
        vecs[1] = '{"ov_bd", 1'b1, 5'd12, 1'b0, 32'h0000_0100, 1'b1, 32'h0, 32'h0, 32'h0,
                    1'b0, 1'b0, 32'h0000_0100, 32'h0000_0030, 32'h0000_0002, 32'h0000_0020};
        vecs[4] = '{"tr_wrap", 1'b1, 5'd13, 1'b0, 32'h0000_0000, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0,
                    1'b0, 1'b0, 32'h0000_0000, 32'h7FFF_FFB7, 32'h0000_0002, 32'h0000_0020};
`endif
        vecs[2] = '{"eret", 1'b0, 5'd0, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0003, 32'h0, 32'h0000_0200,
                    1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0001, 32'h0000_0200};
        vecs[3] = '{"prio", 1'b1, 5'd8, 1'b1, 32'h0000_2000, 1'b0, 32'h0000_8001, 32'h0000_8000, 32'h0000_0500,
                    1'b1, 1'b0, 32'h0000_2000, 32'h0000_8000, 32'h0000_8003, 32'h0000_0020};
        vecs[5] = '{"ri_exl", 1'b1, 5'd10, 1'b0, 32'h0000_0040, 1'b0, 32'h0000_0403, 32'h0000_0400, 32'h0,
                    1'b0, 1'b0, 32'h0000_0040, 32'h0000_0428, 32'h0000_0403, 32'h0000_0020};
        vecs[6] = '{"eret_ie0", 1'b0, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0000_0402, 32'h0000_0400, 32'h0000_0300,
                    1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0400, 32'h0000_0300};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset we",    cp0_we_o,       1'b0);
        checkOutput("reset stall", stall_o,        1'b0);
        checkOutput("reset flush", flush_o,        1'b0);
        checkOutput("reset nvld",  new_pc_valid_o, 1'b0);
        checkOutput("reset npc",   new_pc_o,       32'd0);
        checkOutput("reset addr",  cp0_waddr_o,    5'd0);
        checkOutput("reset data",  cp0_wdata_o,    32'd0);
        rst = 1'b0;

        // No event: IP/IM do not overlap, and IE cleared
        @(negedge clk);
        status_i = 32'h0000_0401;
        cause_i  = 32'h0000_0100;
        #1;
        checkOutput("no overlap flush", flush_o, 1'b0);
        @(negedge clk);
        status_i = 32'h0000_0400;
        cause_i  = 32'h0000_0400;
        #1;
        checkOutput("ie off flush", flush_o, 1'b0);
        @(negedge clk);
        clearInputs();
        checkIdle("no event");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of a sequence abandons it
        @(negedge clk);
        exc_req_i  = 1'b1;
        exc_code_i = EXC_OV;
        exc_pc_i   = 32'h0000_3000;
        #1;
        checkOutput("rst seq flush", flush_o, 1'b1);
        @(negedge clk);
        clearInputs();
        checkWrite("rst seq epc", CP0_EPC, 32'h0000_3000);
        @(negedge clk);
        checkWrite("rst seq cause", CP0_CAUSE, 32'h0000_0030);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdle("rst seq");
        checkOutput("rst seq addr", cp0_waddr_o, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkIdle("rst seq after");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
